// File: rtl/nios2_oci_dct_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios2_oci_dct_pkg
// Brief    : Shared constants and word type for the DCT trace packer.
// Revision : 1.0
// ============================================================================
package nios2_oci_dct_pkg;

    localparam int DCT_DEPTH = 15;
    localparam int DCT_W     = 2 * DCT_DEPTH;

    localparam logic [3:0] DCT_CNT_MAX = 4'(DCT_DEPTH);

    localparam logic [1:0] DCT_NT   = 2'b01;
    localparam logic [1:0] DCT_TK   = 2'b10;
    localparam logic [1:0] DCT_SYNC = 2'b11;

    typedef struct packed {
        logic [DCT_W-1:0] buffer;
        logic [3:0]       count;
    } dct_word_t;

endpackage
`default_nettype wire

// File: rtl/nios2_oci_dct_outreg.sv
`default_nettype none
// ============================================================================
// Module   : nios2_oci_dct_outreg
// Brief    : One-entry valid/ready holding register; drain and reload may
//            happen in the same cycle.
// Revision : 1.0
// ============================================================================
module nios2_oci_dct_outreg
    import nios2_oci_dct_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      load,
    input  dct_word_t load_word,
    input  logic      ready,
    output logic      valid,
    output dct_word_t word
);

    logic      valid_nxt;
    dct_word_t word_nxt;

    always_comb begin
        valid_nxt = valid;
        word_nxt  = word;
        // The producer only loads when the entry is empty or draining now.
        if (load) begin
            valid_nxt = 1'b1;
            word_nxt  = load_word;
        end else if (ready) begin
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            word  <= '0;
        end else begin
            valid <= valid_nxt;
            word  <= word_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios2_system_nios2_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : nios2_system_nios2_oci_dct_packer
// Brief    : Packs 2-bit branch-direction codes into 15-slot DCT words.
// Revision : 1.0
// ============================================================================
module nios2_system_nios2_oci_dct_packer
    import nios2_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             trace_enable,
    input  logic             code_valid,
    input  logic [1:0]       code,
    input  logic             flush,
    output logic [DCT_W-1:0] dct_buffer,
    output logic [3:0]       dct_count,
    output logic             dct_valid,
    input  logic             dct_ready,
    output logic             overflow,
    input  logic             overflow_clr
);

    logic [DCT_W-1:0] acc_buf, acc_buf_nxt, post_buf;
    logic [3:0]       acc_cnt, acc_cnt_nxt, post_cnt;
    logic             flush_pend, flush_pend_nxt;
    logic             te_q;
    logic             overflow_q;
    logic             code_ok, te_fall, full, out_free, pend_req, emit, drop;
    dct_word_t        emit_word, out_word;

    always_comb begin
        code_ok  = trace_enable & code_valid & (code != 2'b00);
        te_fall  = te_q & ~trace_enable;
        full     = (acc_cnt == DCT_CNT_MAX);
        out_free = ~dct_valid | dct_ready;

        post_buf = acc_buf;
        post_cnt = acc_cnt;
        if (code_ok && !full) begin
            post_buf = acc_buf | (DCT_W'(code) << {acc_cnt, 1'b0});
            post_cnt = acc_cnt + 4'd1;
        end

        pend_req = flush | flush_pend | te_fall;
        emit     = out_free & ((post_cnt == DCT_CNT_MAX) | (pend_req & (post_cnt != 4'd0)));
        drop     = code_ok & full & ~out_free;

        emit_word.buffer = post_buf;
        emit_word.count  = post_cnt;

        acc_buf_nxt    = post_buf;
        acc_cnt_nxt    = post_cnt;
        flush_pend_nxt = pend_req & (post_cnt != 4'd0);
        if (emit) begin
            // A full accumulator emits as-is; a code arriving that cycle
            // starts the next word in slot 0.
            if (full && code_ok) begin
                acc_buf_nxt    = DCT_W'(code);
                acc_cnt_nxt    = 4'd1;
                flush_pend_nxt = flush;
            end else begin
                acc_buf_nxt    = '0;
                acc_cnt_nxt    = 4'd0;
                flush_pend_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_buf    <= '0;
            acc_cnt    <= 4'd0;
            flush_pend <= 1'b0;
            te_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            acc_buf    <= acc_buf_nxt;
            acc_cnt    <= acc_cnt_nxt;
            flush_pend <= flush_pend_nxt;
            te_q       <= trace_enable;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    nios2_oci_dct_outreg u_outreg (
        .clk       (clk),
        .reset     (reset),
        .load      (emit),
        .load_word (emit_word),
        .ready     (dct_ready),
        .valid     (dct_valid),
        .word      (out_word)
    );

    assign dct_buffer = out_word.buffer;
    assign dct_count  = out_word.count;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire
